if_fetch_unit: RTL

//  IF-stage producer that drives if_pc/if_instr into the IF/ID pipeline register.

---
 rtl/if_fetch_unit_pkg.sv | 17 +
 rtl/if_fetch_unit_if.sv | 27 ++
 rtl/if_fetch_unit_fetch_buf.sv | 67 ++++++
 rtl/if_fetch_unit.sv | 93 +++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared constants and types for the IF-stage fetch unit.
package if_fetch_unit_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response channel between fetch unit (master) and memory (slave).
interface if_fetch_unit_if;
    import if_fetch_unit_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            resp_valid;
    logic [XLEN-1:0] resp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  resp_valid,
        input  resp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output resp_valid,
        output resp_data
    );

endinterface

// File: rtl/if_fetch_unit_fetch_buf.sv
// Circular fetch buffer: entries are allocated in request order, filled in response order,
// and popped from the head once filled.
module if_fetch_unit_fetch_buf
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 4,
    localparam int unsigned PtrW = $clog2(BUF_DEPTH),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear_i,
    input  logic            alloc_i,
    input  logic [XLEN-1:0] alloc_pc_i,
    input  logic            fill_i,
    input  logic [XLEN-1:0] fill_data_i,
    input  logic            pop_i,
    output logic            head_valid_o,
    output fetch_entry_t    head_o,
    output logic [CntW-1:0] alloc_cnt_o,
    output logic [CntW-1:0] unfilled_cnt_o
);

    fetch_entry_t    entry_q [BUF_DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [CntW-1:0] alloc_ptr_q, alloc_ptr_d;
    logic [CntW-1:0] fill_ptr_q, fill_ptr_d;
    logic [CntW-1:0] head_ptr_q, head_ptr_d;

    always_comb begin
        alloc_ptr_d = alloc_ptr_q;
        fill_ptr_d  = fill_ptr_q;
        head_ptr_d  = head_ptr_q;
        if (clear_i) begin
            alloc_ptr_d = '0;
            fill_ptr_d  = '0;
            head_ptr_d  = '0;
        end else begin
            if (alloc_i) alloc_ptr_d = alloc_ptr_q + CntW'(1);
            if (fill_i)  fill_ptr_d  = fill_ptr_q + CntW'(1);
            if (pop_i)   head_ptr_d  = head_ptr_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            head_ptr_q  <= '0;
        end else begin
            alloc_ptr_q <= alloc_ptr_d;
            fill_ptr_q  <= fill_ptr_d;
            head_ptr_q  <= head_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_i && !clear_i) entry_q[alloc_ptr_q[PtrW-1:0]].pc <= alloc_pc_i;
        if (fill_i && !clear_i)  entry_q[fill_ptr_q[PtrW-1:0]].instr <= fill_data_i;
    end

    assign head_valid_o   = fill_ptr_q != head_ptr_q;
    assign head_o         = entry_q[head_ptr_q[PtrW-1:0]];
    assign alloc_cnt_o    = alloc_ptr_q - head_ptr_q;
    assign unfilled_cnt_o = alloc_ptr_q - fill_ptr_q;

endmodule

// File: rtl/if_fetch_unit.sv
// IF-stage producer: owns the fetch PC, issues in-order imem requests, buffers responses and
// presents one instruction per cycle to IF/ID; redirects flush and drop in-flight responses.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned     BUF_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_stall_i,
    input  logic                   redirect_valid_i,
    input  logic [XLEN-1:0]        redirect_pc_i,
    if_fetch_unit_if.master        imem,
    output logic                   if_valid_o,
    output logic [XLEN-1:0]        if_pc_o,
    output logic [XLEN-1:0]        if_instr_o
);

    localparam int unsigned CntW = $clog2(BUF_DEPTH) + 1;
    localparam logic [CntW:0] DepthW = (CntW + 1)'(BUF_DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CntW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CntW-1:0] alloc_cnt, unfilled_cnt;
    logic [CntW:0]   occupancy;
    logic            req_fire, resp_drop, resp_keep, head_valid, pop;
    fetch_entry_t    head;

    // Dropped responses still hold a slot until they return, so they count against capacity.
    assign occupancy = {1'b0, alloc_cnt} + {1'b0, drop_cnt_q};

    always_comb begin
        imem.req_valid = !rst && !redirect_valid_i && (occupancy < DepthW);
        imem.req_addr  = fetch_pc_q;
    end

    assign req_fire  = imem.req_valid && imem.req_ready;
    assign resp_drop = imem.resp_valid && (drop_cnt_q != '0);
    assign resp_keep = imem.resp_valid && (drop_cnt_q == '0);
    assign pop       = head_valid && !id_stall_i && !redirect_valid_i;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        drop_cnt_d = drop_cnt_q;
        if (resp_drop) drop_cnt_d = drop_cnt_d - CntW'(1);
        if (redirect_valid_i) begin
            fetch_pc_d = word_align(redirect_pc_i);
            // A live response this cycle retires its own slot, so one fewer remains to drop.
            drop_cnt_d = drop_cnt_d + unfilled_cnt;
            if (resp_keep) drop_cnt_d = drop_cnt_d - CntW'(1);
        end else if (req_fire) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    if_fetch_unit_fetch_buf #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_fetch_buf (
        .clk            (clk),
        .rst            (rst),
        .clear_i        (redirect_valid_i),
        .alloc_i        (req_fire),
        .alloc_pc_i     (fetch_pc_q),
        .fill_i         (resp_keep && !redirect_valid_i),
        .fill_data_i    (imem.resp_data),
        .pop_i          (pop),
        .head_valid_o   (head_valid),
        .head_o         (head),
        .alloc_cnt_o    (alloc_cnt),
        .unfilled_cnt_o (unfilled_cnt)
    );

    always_comb begin
        if_valid_o = !rst && head_valid;
        if_pc_o    = if_valid_o ? head.pc : '0;
        if_instr_o = if_valid_o ? head.instr : NOP_INSTR;
    end

    a_resp_has_outstanding : assert property (@(posedge clk) disable iff (rst)
        imem.resp_valid |-> (({1'b0, unfilled_cnt} + {1'b0, drop_cnt_q}) != '0));

endmodule
